// File: rtl/kbus_pixel_writer.sv
`default_nettype none
// ============================================================================
//  Module   : kbus_pixel_writer
//  Purpose  : Buffers 24-bit K-bus pixels in a small FIFO and serializes each
//             one into R, G, B byte writes at a wrapping frame address.
//  Revision : 1.0  initial release
// ============================================================================
module kbus_pixel_writer #(
    parameter int DEPTH       = 4,
    parameter int ADDR_W      = 16,
    parameter int FRAME_BYTES = 49152
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       k_valid,
    input  logic [23:0]                Kbus,
    output logic                       k_ready,
    output logic                       mem_wr,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [7:0]                 mem_data,
    input  logic                       mem_ack,
    output logic                       frame_done,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int              c_ptr_w = $clog2(DEPTH);
    localparam int              c_lvl_w = c_ptr_w + 1;
    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(FRAME_BYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_B0   = 2'd1,
        S_B1   = 2'd2,
        S_B2   = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [23:0]          r_mem [DEPTH];
    logic [c_ptr_w-1:0]   r_wptr;
    logic [c_ptr_w-1:0]   r_rptr;
    logic [c_lvl_w-1:0]   r_level;
    logic [23:0]          r_hold;
    logic [ADDR_W-1:0]    r_addr;
    logic                 r_frame_done;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_ack;
    logic [7:0]           w_data;

    // Readiness looks only at registered occupancy, so mem_ack never reaches k_ready.
    assign k_ready    = rst_n & (r_level < c_lvl_w'(DEPTH));
    assign w_push     = k_valid & k_ready;
    assign w_ack      = mem_ack & (r_state != S_IDLE);
    assign mem_wr     = (r_state != S_IDLE);
    assign mem_data   = w_data;
    assign mem_addr   = r_addr;
    assign frame_done = r_frame_done;
    assign level      = r_level;

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_data      = 8'd0;
        case (r_state)
            S_IDLE: begin
                if (r_level != '0) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_B0;
                end
            end
            S_B0: begin
                w_data = r_hold[23:16];
                if (mem_ack) w_state_nxt = S_B1;
            end
            S_B1: begin
                w_data = r_hold[15:8];
                if (mem_ack) w_state_nxt = S_B2;
            end
            S_B2: begin
                w_data = r_hold[7:0];
                // Back-to-back pixels reload the hold register on the last ack.
                if (mem_ack) begin
                    if (r_level != '0) begin
                        w_pop       = 1'b1;
                        w_state_nxt = S_B0;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= Kbus;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_level      <= '0;
            r_hold       <= '0;
            r_addr       <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_push) r_wptr <= r_wptr + c_ptr_w'(1);
            if (w_pop) begin
                r_rptr <= r_rptr + c_ptr_w'(1);
                r_hold <= r_mem[r_rptr];
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_lvl_w'(1);
                2'b01:   r_level <= r_level - c_lvl_w'(1);
                default: r_level <= r_level;
            endcase
            r_frame_done <= 1'b0;
            if (w_ack) begin
                if (r_addr == c_last_addr) begin
                    r_addr       <= '0;
                    r_frame_done <= 1'b1;
                end else begin
                    r_addr <= r_addr + ADDR_W'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_kbus_pixel_writer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_kbus_pixel_writer
//  Purpose  : Directed and randomized self-checking bench for kbus_pixel_writer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_kbus_pixel_writer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        k_valid = 1'b0;
    logic [23:0] Kbus = '0;
    logic        mem_ack = 1'b0;

    logic        k_ready, mem_wr, frame_done;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data;
    logic [2:0]  level;
    logic        k_ready_f, mem_wr_f, frame_done_f;
    logic [15:0] mem_addr_f;
    logic [7:0]  mem_data_f;
    logic [2:0]  level_f;

    kbus_pixel_writer #(.DEPTH(4), .ADDR_W(16), .FRAME_BYTES(49152)) dut (
        .clk(clk), .rst_n(rst_n), .k_valid(k_valid), .Kbus(Kbus),
        .k_ready(k_ready), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_data(mem_data), .mem_ack(mem_ack), .frame_done(frame_done),
        .level(level)
    );

    kbus_pixel_writer #(.DEPTH(4), .ADDR_W(16), .FRAME_BYTES(6)) dut_f (
        .clk(clk), .rst_n(rst_n), .k_valid(k_valid), .Kbus(Kbus),
        .k_ready(k_ready_f), .mem_wr(mem_wr_f), .mem_addr(mem_addr_f),
        .mem_data(mem_data_f), .mem_ack(mem_ack), .frame_done(frame_done_f),
        .level(level_f)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [7:0]  exp_q [$];
    logic [15:0] exp_a = '0;
    logic [15:0] exp_f = '0;
    int          nbytes = 0;
    int          fd_f_cnt = 0;
    logic [23:0] words [6] = '{24'hA1B2C3, 24'h102030, 24'hFFEE01,
                               24'h00AA55, 24'h7E8191, 24'h0F0E0D};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scores accepted bytes and pushes just before each edge, then advances one cycle.
    task automatic tick();
        logic       fa, ff;
        logic [7:0] b;
        fa = 1'b0;
        ff = 1'b0;
        if (rst_n) begin
            if (mem_wr && mem_ack) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_wr", 1, 0);
                end else begin
                    b = exp_q.pop_front();
                    chk("data", mem_data, b);
                    chk("data_f", mem_data_f, b);
                end
                chk("addr", mem_addr, exp_a);
                chk("addr_f", mem_addr_f, exp_f);
                fa = (exp_a == 16'd49151);
                ff = (exp_f == 16'd5);
                exp_a = fa ? 16'd0 : exp_a + 16'd1;
                exp_f = ff ? 16'd0 : exp_f + 16'd1;
                nbytes++;
            end
            if (k_valid && k_ready) begin
                exp_q.push_back(Kbus[23:16]);
                exp_q.push_back(Kbus[15:8]);
                exp_q.push_back(Kbus[7:0]);
            end
        end
        @(posedge clk);
        #1;
        if (!rst_n) begin
            exp_q.delete();
            exp_a = '0;
            exp_f = '0;
        end else begin
            chk("frame_done", frame_done, fa);
            chk("frame_done_f", frame_done_f, ff);
            if (frame_done_f) fd_f_cnt++;
        end
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        k_valid = 1'b0;
        mem_ack = 1'b0;
        tick();
        chk("rst_level", level, 0);
        chk("rst_mem_wr", mem_wr, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_data", mem_data, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_k_ready", k_ready, 0);
        rst_n    = 1'b1;
        fd_f_cnt = 0;
        nbytes   = 0;
        tick();
        chk("rel_k_ready", k_ready, 1);
    endtask

    task automatic drain();
        int c;
        k_valid = 1'b0;
        mem_ack = 1'b1;
        c = 0;
        while ((mem_wr || mem_wr_f || level != 0) && c < 500) begin
            tick();
            c++;
        end
        if (c >= 500) chk("drain_timeout", 1, 0);
        mem_ack = 1'b0;
        chk("model_empty", exp_q.size(), 0);
    endtask

    initial begin
        int  i, c, hi, n;
        logic acc, rose, done;

        // single pixel, latency and byte order
        do_reset();
        k_valid = 1'b1;
        Kbus    = 24'hA1B2C3;
        tick();
        k_valid = 1'b0;
        chk("lat_no_wr", mem_wr, 0);
        chk("lat_level", level, 1);
        tick();
        chk("lat_wr", mem_wr, 1);
        chk("lat_r", mem_data, 8'hA1);
        chk("lat_r_addr", mem_addr, 0);
        chk("lat_level0", level, 0);
        mem_ack = 1'b1;
        tick();
        chk("g_byte", mem_data, 8'hB2);
        chk("g_addr", mem_addr, 1);
        tick();
        chk("b_byte", mem_data, 8'hC3);
        chk("b_addr", mem_addr, 2);
        tick();
        chk("idle_wr", mem_wr, 0);
        chk("idle_addr", mem_addr, 3);
        mem_ack = 1'b0;

        // six back-to-back words, continuous mem_wr
        do_reset();
        mem_ack = 1'b1;
        i = 0; hi = 0; rose = 1'b0; done = 1'b0; c = 0;
        while (!done && c < 200) begin
            k_valid = (i < 6);
            if (i < 6) Kbus = words[i];
            acc = k_valid && k_ready;
            chk("level_max", level <= 3'd4, 1);
            tick();
            if (acc) i++;
            if (mem_wr) begin
                hi++;
                rose = 1'b1;
            end else if (rose) begin
                done = 1'b1;
            end
            c++;
        end
        k_valid = 1'b0;
        chk("burst_pushed", i, 6);
        chk("burst_len", hi, 18);
        chk("burst_addr", mem_addr, 18);
        drain();

        // backpressure: outputs frozen, FIFO fills
        do_reset();
        mem_ack = 1'b0;
        i = 0;
        for (int k = 0; k < 12; k++) begin
            k_valid = 1'b1;
            Kbus    = words[i];
            acc     = k_ready;
            tick();
            if (acc && i < 5) i++;
            if (k >= 1) begin
                chk("stall_wr", mem_wr, 1);
                chk("stall_data", mem_data, words[0][23:16]);
                chk("stall_addr", mem_addr, 0);
            end
        end
        chk("stall_level", level, 4);
        chk("stall_k_ready", k_ready, 0);
        chk("stall_accepted", i, 5);
        mem_ack = 1'b1;
        acc = 1'b0; c = 0;
        while (!acc && c < 20) begin
            acc = k_ready;
            tick();
            c++;
        end
        k_valid = 1'b0;
        chk("sixth_accepted", acc, 1);
        drain();
        chk("stall_bytes", nbytes, 18);

        // frame wrap on the FRAME_BYTES=6 instance
        do_reset();
        mem_ack = 1'b1;
        i = 0; c = 0;
        while (i < 3 && c < 50) begin
            k_valid = 1'b1;
            Kbus    = words[i + 1];
            acc     = k_ready;
            tick();
            if (acc) i++;
            c++;
        end
        drain();
        chk("frame_pulses", fd_f_cnt, 1);
        chk("frame_addr_f", mem_addr_f, 3);

        // reset in B1 with two words queued
        do_reset();
        mem_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            k_valid = 1'b1;
            Kbus    = words[k + 2];
            tick();
        end
        k_valid = 1'b0;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("mid_level", level, 2);
        chk("mid_g", mem_data, words[2][15:8]);
        do_reset();
        mem_ack = 1'b1;
        hi = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (mem_wr) hi++;
        end
        chk("no_residual_wr", hi, 0);
        k_valid = 1'b1;
        Kbus    = 24'h123456;
        tick();
        drain();
        chk("post_rst_addr", mem_addr, 3);

        // random handshakes over 1000 words
        do_reset();
        n = 0; c = 0; acc = 1'b1;
        while (n < 1000 && c < 30000) begin
            if (acc || !k_valid) Kbus = 24'($urandom);
            k_valid = 1'($urandom_range(0, 1));
            mem_ack = 1'($urandom_range(0, 1));
            acc = k_valid && k_ready;
            tick();
            if (acc) n++;
            c++;
        end
        if (c >= 30000) chk("random_timeout", 1, 0);
        drain();
        chk("random_bytes", nbytes, 3000);
        chk("random_addr", mem_addr, 3000);
        chk("random_addr_f", mem_addr_f, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
